// File: rtl/i2c_slave.sv
// 7-bit-address I2C slave with oversampled SCL/SDA, multi-byte write and read.
// Optional SCL/SDA glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] slave_addr_i,
    input  logic [7:0] tx_data_i,
    output logic [7:0] rx_data_o,
    output logic       addr_match_o,
    output logic       ack_sent_o,
    output logic       data_valid_o,
    input  logic       scl_i,
    inout  wire        sda_io,
    output logic [1:0] debug_state_o,
    output logic       debug_sda_out_o,
    output logic       debug_sda_oe_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic scl_f, sda_f, scl_prev_q, sda_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda_io;
            sda_s2_q <= sda_s1_q;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // The filtered level follows the synchronizer once three samples agree.
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_hold_q, sda_hold_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_hold_q <= 1'b1;
            sda_hold_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_s2_q};
            sda_hist_q <= {sda_hist_q[0], sda_s2_q};
            scl_hold_q <= scl_f;
            sda_hold_q <= sda_f;
        end
    end

    assign scl_f = ({scl_hist_q, scl_s2_q} == 3'b111) ? 1'b1 :
                   ({scl_hist_q, scl_s2_q} == 3'b000) ? 1'b0 : scl_hold_q;
    assign sda_f = ({sda_hist_q, sda_s2_q} == 3'b111) ? 1'b1 :
                   ({sda_hist_q, sda_s2_q} == 3'b000) ? 1'b0 : sda_hold_q;
`else
    assign scl_f = scl_s2_q;
    assign sda_f = sda_s2_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
        end
    end

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, tx_shift_q, tx_shift_d, rx_data_q, rx_data_d;
    logic       data_valid_q, data_valid_d, addr_match_q, addr_match_d;
    logic       ack_q, ack_d, load_q, load_d, sda_oe_q, sda_oe_d, sda_out_q, sda_out_d;

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    // Bus conditions are ignored while this slave drives SDA itself.
    assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f & ~sda_oe_q;
    assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f & ~sda_oe_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'd0;
            tx_shift_q   <= 8'd0;
            rx_data_q    <= 8'd0;
            data_valid_q <= 1'b0;
            addr_match_q <= 1'b0;
            ack_q        <= 1'b0;
            load_q       <= 1'b0;
            sda_oe_q     <= 1'b0;
            sda_out_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_shift_q   <= tx_shift_d;
            rx_data_q    <= rx_data_d;
            data_valid_q <= data_valid_d;
            addr_match_q <= addr_match_d;
            ack_q        <= ack_d;
            load_q       <= load_d;
            sda_oe_q     <= sda_oe_d;
            sda_out_q    <= sda_out_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_shift_d   = tx_shift_q;
        rx_data_d    = rx_data_q;
        data_valid_d = data_valid_q;
        addr_match_d = addr_match_q;
        ack_d        = ack_q;
        load_d       = load_q;
        sda_oe_d     = sda_oe_q;
        sda_out_d    = sda_out_q;
        if (start_det) begin
            state_d      = ST_ADDR;
            bit_cnt_d    = 4'd0;
            addr_match_d = 1'b0;
            data_valid_d = 1'b0;
            ack_d        = 1'b0;
            load_d       = 1'b0;
            sda_oe_d     = 1'b0;
            sda_out_d    = 1'b0;
        end else if (stop_det) begin
            state_d      = ST_IDLE;
            bit_cnt_d    = 4'd0;
            addr_match_d = 1'b0;
            ack_d        = 1'b0;
            load_d       = 1'b0;
            sda_oe_d     = 1'b0;
            sda_out_d    = 1'b0;
        end else if (state_q != ST_IDLE) begin
            if (scl_rise) begin
                if (bit_cnt_q == 4'd8) begin
                    // Ninth clock: ACK slot. In READ this carries the master's ACK/NACK.
                    bit_cnt_d = 4'd0;
                    if (state_q == ST_READ) begin
                        if (sda_f) state_d = ST_IDLE;
                        else       load_d  = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    shift_d   = {shift_q[6:0], sda_f};
                    if (state_q == ST_WRITE) begin
                        if (bit_cnt_q == 4'd0) data_valid_d = 1'b0;
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d    = {shift_q[6:0], sda_f};
                            data_valid_d = 1'b1;
                        end
                    end
                end
            end else if (scl_fall) begin
                if (bit_cnt_q == 4'd8) begin
                    if (state_q == ST_READ) begin
                        sda_oe_d  = 1'b0;
                        sda_out_d = 1'b0;
                    end else if (state_q == ST_ADDR && shift_q[7:1] != slave_addr_i) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = 4'd0;
                    end else begin
                        sda_oe_d  = 1'b1;
                        sda_out_d = 1'b0;
                        ack_d     = 1'b1;
                        if (state_q == ST_ADDR) addr_match_d = 1'b1;
                    end
                end else if (ack_q) begin
                    ack_d = 1'b0;
                    if (state_q == ST_ADDR && shift_q[0]) begin
                        state_d    = ST_READ;
                        sda_oe_d   = 1'b1;
                        sda_out_d  = tx_data_i[7];
                        tx_shift_d = {tx_data_i[6:0], 1'b0};
                    end else begin
                        sda_oe_d  = 1'b0;
                        sda_out_d = 1'b0;
                        if (state_q == ST_ADDR) state_d = ST_WRITE;
                    end
                end else if (load_q) begin
                    load_d     = 1'b0;
                    sda_oe_d   = 1'b1;
                    sda_out_d  = tx_data_i[7];
                    tx_shift_d = {tx_data_i[6:0], 1'b0};
                end else if (state_q == ST_READ && bit_cnt_q != 4'd0) begin
                    sda_out_d  = tx_shift_q[7];
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
        end
    end

    assign sda_io          = sda_oe_q ? sda_out_q : 1'bz;
    assign rx_data_o       = rx_data_q;
    assign addr_match_o    = addr_match_q;
    assign ack_sent_o      = ack_q;
    assign data_valid_o    = data_valid_q;
    assign debug_state_o   = state_q;
    assign debug_sda_out_o = sda_out_q;
    assign debug_sda_oe_o  = sda_oe_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged I2C master on an open-drain SDA line.
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] slave_addr = 7'h00;
    logic [7:0] tx_data = 8'h00;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda_w;
    logic [7:0] rx_data;
    logic       addr_match, ack_sent, data_valid, dbg_out, dbg_oe;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail = 0;
    int oe_cycles = 0;
    logic sample_sda, sample_ack_sent;

    always #5 clk = ~clk;

    pullup (sda_w);
    assign sda_w = m_low ? 1'b0 : 1'bz;

    always @(posedge clk) if (dbg_oe) oe_cycles <= oe_cycles + 1;

    i2c_slave dut (
        .clk_i(clk), .rst_i(rst), .slave_addr_i(slave_addr), .tx_data_i(tx_data),
        .rx_data_o(rx_data), .addr_match_o(addr_match), .ack_sent_o(ack_sent),
        .data_valid_o(data_valid), .scl_i(scl), .sda_io(sda_w),
        .debug_state_o(dbg_state), .debug_sda_out_o(dbg_out), .debug_sda_oe_o(dbg_oe)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; wait_clk(5);
        scl = 1'b1;   wait_clk(10);
        m_low = 1'b1; wait_clk(10);
        scl = 1'b0;   wait_clk(10);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; wait_clk(10);
        scl = 1'b1;   wait_clk(10);
        m_low = 1'b0; wait_clk(20);
    endtask

    // Data set mid-low, sampled mid-high; master lets go of SDA 2 clk after SCL falls.
    task automatic i2c_bit(input logic b);
        m_low = ~b;   wait_clk(10);
        scl = 1'b1;   wait_clk(10);
        sample_sda = sda_w;
        sample_ack_sent = ack_sent;
        wait_clk(10);
        scl = 1'b0;   wait_clk(2);
        m_low = 1'b0; wait_clk(8);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked, output logic ack_flag);
        for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
        i2c_bit(1'b1);
        acked = ~sample_sda;
        ack_flag = sample_ack_sent;
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1);
            d[i] = sample_sda;
        end
        i2c_bit(~m_ack);
    endtask

    task automatic test_reset();
        wait_clk(5);
        n_checks++; if (dbg_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe_in_rst: got %b want 0", dbg_oe); end
        rst = 1'b0;
        wait_clk(5);
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL reset_addr_match: got %b want 0", addr_match); end
        n_checks++; if (ack_sent !== 1'b0) begin n_fail++; $display("FAIL reset_ack_sent: got %b want 0", ack_sent); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        n_checks++; if (dbg_oe !== 1'b0 || dbg_out !== 1'b0) begin n_fail++; $display("FAIL reset_sda_drv: got oe=%b out=%b want 0/0", dbg_oe, dbg_out); end
        n_checks++; if (sda_w !== 1'b1) begin n_fail++; $display("FAIL reset_sda_line: got %b want 1", sda_w); end
    endtask

    task automatic test_write();
        logic acked, flag;
        slave_addr = 7'h55;
        i2c_start();
        write_byte({7'h55, 1'b0}, acked, flag);
        n_checks++; if (acked !== 1'b1) begin n_fail++; $display("FAIL write_addr_ack: got %b want 1", acked); end
        n_checks++; if (flag !== 1'b1) begin n_fail++; $display("FAIL write_ack_sent: got %b want 1", flag); end
        n_checks++; if (addr_match !== 1'b1) begin n_fail++; $display("FAIL write_addr_match: got %b want 1", addr_match); end
        n_checks++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL write_state: got %0d want 2", dbg_state); end
        write_byte(8'h42, acked, flag);
        n_checks++; if (acked !== 1'b1) begin n_fail++; $display("FAIL write_data_ack: got %b want 1", acked); end
        n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL write_data_valid: got %b want 1", data_valid); end
        n_checks++; if (rx_data !== 8'h42) begin n_fail++; $display("FAIL write_rx_data: got %h want 42", rx_data); end
        n_checks++; if (dbg_oe !== 1'b0) begin n_fail++; $display("FAIL write_release_after_ack: got %b want 0", dbg_oe); end
        i2c_stop();
        n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL write_stop_match: got %b want 0", addr_match); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL write_stop_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_read();
        logic acked, flag;
        logic [7:0] d;
        tx_data = 8'h5A;
        i2c_start();
        write_byte({7'h55, 1'b1}, acked, flag);
        n_checks++; if (acked !== 1'b1) begin n_fail++; $display("FAIL read_addr_ack: got %b want 1", acked); end
        n_checks++; if (addr_match !== 1'b1) begin n_fail++; $display("FAIL read_addr_match: got %b want 1", addr_match); end
        n_checks++; if (dbg_state !== 2'd3) begin n_fail++; $display("FAIL read_state: got %0d want 3", dbg_state); end
        read_byte(1'b0, d);
        n_checks++; if (d !== 8'h5A) begin n_fail++; $display("FAIL read_data: got %h want 5a", d); end
        n_checks++; if (dbg_oe !== 1'b0) begin n_fail++; $display("FAIL read_release_before_stop: got %b want 0", dbg_oe); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL read_nack_state: got %0d want 0", dbg_state); end
        i2c_stop();
    endtask

    task automatic test_wrong_addr();
        logic acked, flag;
        int oe_before;
        oe_before = oe_cycles;
        i2c_start();
        write_byte({7'h33, 1'b0}, acked, flag);
        n_checks++; if (acked !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_ack: got %b want 0", acked); end
        write_byte(8'h42, acked, flag);
        n_checks++; if (acked !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_data_ack: got %b want 0", acked); end
        n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_match: got %b want 0", addr_match); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_data_valid: got %b want 0", data_valid); end
        i2c_stop();
        n_checks++; if (oe_cycles !== oe_before) begin n_fail++; $display("FAIL wrong_addr_sda_driven: got %0d cycles want 0", oe_cycles - oe_before); end
    endtask

    task automatic test_multi_write();
        logic acked, flag;
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        i2c_start();
        write_byte({7'h55, 1'b0}, acked, flag);
        n_checks++; if (acked !== 1'b1) begin n_fail++; $display("FAIL multi_addr_ack: got %b want 1", acked); end
        for (int k = 0; k < 3; k++) begin
            write_byte(vals[k], acked, flag);
            n_checks++; if (acked !== 1'b1 || flag !== 1'b1) begin n_fail++; $display("FAIL multi_ack_%0d: got ack=%b flag=%b want 1/1", k, acked, flag); end
            n_checks++; if (data_valid !== 1'b1 || rx_data !== vals[k]) begin n_fail++; $display("FAIL multi_data_%0d: got dv=%b rx=%h want 1/%h", k, data_valid, rx_data, vals[k]); end
        end
        i2c_stop();
    endtask

    task automatic test_back_to_back();
        logic acked, flag;
        logic [7:0] d;
        tx_data = 8'hA5;
        i2c_start();
        write_byte({7'h55, 1'b1}, acked, flag);
        tx_data = 8'hC3;
        read_byte(1'b1, d);
        n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL b2b_read0: got %h want a5", d); end
        n_checks++; if (dbg_state !== 2'd3) begin n_fail++; $display("FAIL b2b_state_after_mack: got %0d want 3", dbg_state); end
        read_byte(1'b0, d);
        n_checks++; if (d !== 8'hC3) begin n_fail++; $display("FAIL b2b_read1: got %h want c3", d); end
        i2c_start();
        n_checks++; if (dbg_state !== 2'd1 || addr_match !== 1'b0) begin n_fail++; $display("FAIL b2b_rstart: got state=%0d match=%b want 1/0", dbg_state, addr_match); end
        write_byte({7'h55, 1'b0}, acked, flag);
        write_byte(8'h7E, acked, flag);
        n_checks++; if (acked !== 1'b1 || rx_data !== 8'h7E || data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_write: got ack=%b rx=%h dv=%b want 1/7e/1", acked, rx_data, data_valid); end
        i2c_stop();
    endtask

    task automatic test_reset_mid();
        logic acked, flag;
        i2c_start();
        i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1);
        rst = 1'b1; wait_clk(2);
        n_checks++; if (dbg_oe !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_mid_addr: got oe=%b state=%0d want 0/0", dbg_oe, dbg_state); end
        rst = 1'b0; wait_clk(5);
        i2c_stop();
        // Reset again while the slave is actively pulling SDA for the ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) i2c_bit(8'hAA >> i);
        wait_clk(10); scl = 1'b1; wait_clk(5);
        n_checks++; if (dbg_oe !== 1'b1 || sda_w !== 1'b0) begin n_fail++; $display("FAIL rst_pre_ack: got oe=%b sda=%b want 1/0", dbg_oe, sda_w); end
        rst = 1'b1; wait_clk(2);
        n_checks++; if (dbg_oe !== 1'b0 || sda_w !== 1'b1 || ack_sent !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_in_ack: got oe=%b sda=%b ack=%b state=%0d want 0/1/0/0", dbg_oe, sda_w, ack_sent, dbg_state); end
        rst = 1'b0; wait_clk(5);
        scl = 1'b0; wait_clk(10);
        i2c_stop();
        i2c_start();
        write_byte({7'h55, 1'b0}, acked, flag);
        write_byte(8'h9C, acked, flag);
        n_checks++; if (acked !== 1'b1 || rx_data !== 8'h9C || addr_match !== 1'b1) begin n_fail++; $display("FAIL rst_recover: got ack=%b rx=%h match=%b want 1/9c/1", acked, rx_data, addr_match); end
        i2c_stop();
    endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    task automatic test_glitch();
        logic acked, flag;
        logic [7:0] b = 8'h96;
        i2c_start();
        write_byte({7'h55, 1'b0}, acked, flag);
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(b[i]);
            if (i == 4) begin
                scl = 1'b1; wait_clk(1);
                scl = 1'b0; wait_clk(5);
            end
        end
        i2c_bit(1'b1);
        n_checks++; if (sample_sda !== 1'b0 || rx_data !== 8'h96) begin n_fail++; $display("FAIL glitch_data: got sda=%b rx=%h want 0/96", sample_sda, rx_data); end
        i2c_stop();
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrong_addr();
        test_multi_write();
        test_back_to_back();
        test_reset_mid();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
